round_robin_rotating_arbiter: RTL and testbench
===============================================

Name: round_robin_rotating_arbiter

Overview:
Shares one resource among N requesters with fair round-robin priority. Priority is rotated by a circular shift of the request vector by a registered pointer. The block sits in front of any shared datapath unit, such as a shared shifter or bus port. A grant is held until the holder releases it or until a hold-time limit expires.

Parameters:
N, 4, number of requesters (N >= 2)
MAX_HOLD, 8, maximum cycles a grant may be held before forced preemption; 0 disables the limit
IDX_W, $clog2(N), width of the grant index

Ports:
clk  input  1  clock, all logic on the rising edge
rst  input  1  synchronous reset, active-high
req  input  N  request vector, bit i = requester i wants the resource
release  input  1  holder finishes; sampled only while busy
grant  output  N  one-hot grant, registered
grant_idx  output  IDX_W  binary index of the granted requester; valid when busy
busy  output  1  a grant is active
preempted  output  1  single-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Clock and reset:
  - Single clock clk.
  - Reset is synchronous and active-high on rst.
- Reset values:
  - grant=0, grant_idx=0, busy=0, preempted=0.
  - Priority pointer ptr=0, hold counter=0, state IDLE.
- States: IDLE and BUSY.
- Arbitration function, combinational:
  - Rotate req right circularly by ptr.
  - Pick the lowest set bit.
  - Add ptr mod N to get the winner index.
  - Requester ptr has highest priority; ptr-1 mod N has lowest.
- IDLE:
  - If req != 0, the next edge sets grant=one-hot(winner), grant_idx=winner, busy=1, ptr=(winner+1) mod N, hold counter=1.
  - Grant latency is 1 cycle from req sampled high.
  - If req == 0, stay in IDLE with outputs unchanged at zero.
- BUSY, hold phase:
  - Grant is stable regardless of req changes, including the holder dropping its req bit.
  - release is the only normal exit.
  - Each cycle without release or preemption, the hold counter increments, saturating at MAX_HOLD.
- BUSY, release:
  - On release=1, arbitrate in the same cycle over req with the holder's bit masked.
  - If another requester wins, the next edge grants it directly (back-to-back, no idle bubble), updates ptr, and sets hold counter=1.
  - If no other request exists, go to IDLE with grant=0 and busy=0.
  - The holder can therefore never win immediately after its own release. It regains the resource only via IDLE on a later cycle.
- BUSY, preemption (MAX_HOLD>0):
  - When the hold counter == MAX_HOLD and release=0, treat the cycle as a release (same masked arbitration).
  - Assert preempted=1 for exactly one cycle, coincident with the edge that changes or clears grant.
  - If release=1 in the same cycle, the exit is a normal release and preempted=0.
- Invariants:
  - grant is always zero or one-hot.
  - grant_idx == index of the set grant bit whenever busy=1.
- Reset mid-operation: rst overrides every other input in that cycle; all state returns to reset values at that edge.
- req bits outside a grant event are never latched; the block has no request memory.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, BUSY)
  - a function computing the one-hot-to-index conversion
- One sub-module is natural: circular_right_rotate_by_variable.
  - Parameter N; inputs a[N], amount[IDX_W]; output res[N].
  - Instantiated twice: rotate req right, and rotate the selected one-hot left (or add ptr to the index).
- Arbitration stays in the top module.

Test Plan:
1. Reset then req=4'b0000 for 5 cycles -> grant=0, busy=0, preempted=0 throughout.
2. From reset (ptr=0), req=4'b1010 -> one cycle later grant=4'b0010, grant_idx=1, busy=1. Release with req=4'b1010 -> next edge grant=4'b1000, idx=3, with no busy gap.
3. Fairness: req=4'b1111 held, release pulsed every 2nd cycle -> grant sequence 0001, 0010, 0100, 1000, 0001.
4. Holder masking: grant on 0, req=4'b0001 only, release=1 -> next edge grant=0, busy=0. The following cycle grant=4'b0001 again.
5. Preemption, MAX_HOLD=3: grant on 2, req=4'b0101, no release -> after 3 cycles of grant, preempted pulses once and grant=4'b0001.
6. rst asserted while busy with grant=4'b0100 -> next edge all outputs 0, ptr=0. Then req=4'b1100 grants 4'b0100.

Source files
------------

// File: rtl/round_robin_rotating_arbiter_pkg.sv
// Shared types and helpers for the round-robin rotating arbiter.
package round_robin_rotating_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Widest request vector the index helper accepts; callers zero-extend.
    localparam int unsigned MAX_REQ = 64;

    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/round_robin_rotating_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface round_robin_rotating_arbiter_if #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
);
    logic [N-1:0]     req;
    logic             rel;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             busy;
    logic             preempted;

    modport master (
        output req, rel,
        input  grant, grant_idx, busy, preempted
    );

    modport slave (
        input  req, rel,
        output grant, grant_idx, busy, preempted
    );
endinterface

// File: rtl/round_robin_rotating_arbiter_rotate.sv
// Circular right rotate of an N-bit vector by a variable amount (0..N).
module circular_right_rotate_by_variable #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     a,
    input  logic [IDX_W-1:0] amount,
    output logic [N-1:0]     res
);
    logic [2*N-1:0] dbl_sh;

    // Shifting the doubled vector makes the low half the rotated result.
    assign dbl_sh = {a, a} >> amount;
    assign res    = dbl_sh[N-1:0];
endmodule

// File: rtl/round_robin_rotating_arbiter.sv
// Round-robin arbiter with grant hold, release and MAX_HOLD preemption.
module round_robin_rotating_arbiter
    import round_robin_rotating_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic clk,
    input  logic rst,
    round_robin_rotating_arbiter_if.slave arb_io
);
    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    arb_state_e         state_q;
    logic [N-1:0]       grant_q;
    logic [IDX_W-1:0]   grant_idx_q;
    logic               busy_q;
    logic               preempted_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [HOLD_W-1:0]  hold_q;

    logic [N-1:0]       masked_req;
    logic [N-1:0]       rot_req;
    logic [N-1:0]       rot_sel;
    logic [N-1:0]       win_oh;
    logic [IDX_W-1:0]   back_amt;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   ptr_d;
    logic [MAX_REQ-1:0] win_oh_ext;
    logic               any_win;
    logic               expire;

    // Outside BUSY grant_q is zero, so masking with it only excludes the holder.
    assign masked_req = arb_io.req & ~grant_q;

    circular_right_rotate_by_variable #(.N(N), .IDX_W(IDX_W)) u_rot_req (
        .a      (masked_req),
        .amount (ptr_q),
        .res    (rot_req)
    );

    assign rot_sel  = rot_req & (-rot_req);
    assign any_win  = |rot_req;
    // Rotating right by N - ptr undoes the right rotation by ptr.
    assign back_amt = IDX_W'(N) - ptr_q;

    circular_right_rotate_by_variable #(.N(N), .IDX_W(IDX_W)) u_rot_back (
        .a      (rot_sel),
        .amount (back_amt),
        .res    (win_oh)
    );

    always_comb begin
        win_oh_ext          = '0;
        win_oh_ext[N-1:0]   = win_oh;
    end

    assign win_idx = IDX_W'(onehot_to_idx(win_oh_ext));
    assign ptr_d   = (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + 1'b1;
    assign expire  = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            busy_q      <= 1'b0;
            preempted_q <= 1'b0;
            ptr_q       <= '0;
            hold_q      <= '0;
        end else begin
            preempted_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_win) begin
                        state_q     <= BUSY;
                        grant_q     <= win_oh;
                        grant_idx_q <= win_idx;
                        busy_q      <= 1'b1;
                        ptr_q       <= ptr_d;
                        hold_q      <= HOLD_W'(1);
                    end
                end
                BUSY: begin
                    if (arb_io.rel || expire) begin
                        preempted_q <= !arb_io.rel;
                        if (any_win) begin
                            grant_q     <= win_oh;
                            grant_idx_q <= win_idx;
                            ptr_q       <= ptr_d;
                            hold_q      <= HOLD_W'(1);
                        end else begin
                            state_q     <= IDLE;
                            grant_q     <= '0;
                            grant_idx_q <= '0;
                            busy_q      <= 1'b0;
                            hold_q      <= '0;
                        end
                    end else if (MAX_HOLD != 0 && hold_q != HOLD_W'(MAX_HOLD)) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb_io.grant     = grant_q;
    assign arb_io.grant_idx = grant_idx_q;
    assign arb_io.busy      = busy_q;
    assign arb_io.preempted = preempted_q;
endmodule

// File: tb/tb_round_robin_rotating_arbiter.sv
// Directed plus random stimulus against a priority-walk reference model.
module tb_round_robin_rotating_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    round_robin_rotating_arbiter_if #(.N(N)) arb_if ();

    round_robin_rotating_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_io (arb_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit m_busy;
    int m_holder;
    int m_ptr;
    int m_held;
    bit m_pre;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Walk the priority order starting at p, skipping the given requester.
    function automatic int pick(input logic [N-1:0] r, input int skip, input int p);
        int c;
        for (int k = 0; k < N; k++) begin
            c = (p + k) % N;
            if (r[c] && c != skip) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input bit rl, input bit rs);
        int w;
        bit expired;
        m_pre = 1'b0;
        if (rs) begin
            m_busy = 1'b0; m_holder = 0; m_ptr = 0; m_held = 0;
        end else if (!m_busy) begin
            w = pick(r, -1, m_ptr);
            if (w >= 0) begin
                m_busy = 1'b1; m_holder = w; m_ptr = (w + 1) % N; m_held = 1;
            end
        end else begin
            expired = (MAX_HOLD > 0) && (m_held >= MAX_HOLD);
            if (rl || expired) begin
                m_pre = !rl;
                w = pick(r, m_holder, m_ptr);
                if (w >= 0) begin
                    m_holder = w; m_ptr = (w + 1) % N; m_held = 1;
                end else begin
                    m_busy = 1'b0; m_holder = 0; m_held = 0;
                end
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] r, input bit rl, input bit rs);
        arb_if.req = r;
        arb_if.rel = rl;
        rst        = rs;
        @(posedge clk);
        model_step(r, rl, rs);
        #1;
        chk("grant",     32'(arb_if.grant),     m_busy ? (32'd1 << m_holder) : 32'd0);
        chk("grant_idx", 32'(arb_if.grant_idx), m_busy ? 32'(m_holder) : 32'd0);
        chk("busy",      32'(arb_if.busy),      32'(m_busy));
        chk("preempted", 32'(arb_if.preempted), 32'(m_pre));
        chk("onehot0",   32'($onehot0(arb_if.grant)), 32'd1);
    endtask

    initial begin
        arb_if.req = '0;
        arb_if.rel = 1'b0;
        rst        = 1'b1;
        m_busy = 0; m_holder = 0; m_ptr = 0; m_held = 0; m_pre = 0;

        // Idle with no requests
        step(4'b0000, 0, 1);
        for (int i = 0; i < 5; i++) step(4'b0000, 0, 0);
        chk("t1_grant", 32'(arb_if.grant), 32'd0);

        // Back-to-back handoff on release
        step(4'b0000, 0, 1);
        step(4'b1010, 0, 0);
        chk("t2_grant0", 32'(arb_if.grant), 32'b0010);
        chk("t2_idx0", 32'(arb_if.grant_idx), 32'd1);
        step(4'b1010, 1, 0);
        chk("t2_grant1", 32'(arb_if.grant), 32'b1000);
        chk("t2_busy1", 32'(arb_if.busy), 32'd1);

        // Fairness rotation
        step(4'b0000, 0, 1);
        step(4'b1111, 0, 0);
        chk("t3_g0", 32'(arb_if.grant), 32'b0001);
        step(4'b1111, 0, 0);
        step(4'b1111, 1, 0);
        chk("t3_g1", 32'(arb_if.grant), 32'b0010);
        step(4'b1111, 0, 0);
        step(4'b1111, 1, 0);
        chk("t3_g2", 32'(arb_if.grant), 32'b0100);
        step(4'b1111, 0, 0);
        step(4'b1111, 1, 0);
        chk("t3_g3", 32'(arb_if.grant), 32'b1000);
        step(4'b1111, 0, 0);
        step(4'b1111, 1, 0);
        chk("t3_g4", 32'(arb_if.grant), 32'b0001);

        // Holder cannot re-win on its own release
        step(4'b0000, 0, 1);
        step(4'b0001, 0, 0);
        step(4'b0001, 1, 0);
        chk("t4_grant_rel", 32'(arb_if.grant), 32'd0);
        chk("t4_busy_rel", 32'(arb_if.busy), 32'd0);
        step(4'b0001, 0, 0);
        chk("t4_regrant", 32'(arb_if.grant), 32'b0001);

        // Preemption after MAX_HOLD cycles
        step(4'b0000, 0, 1);
        step(4'b0100, 0, 0);
        step(4'b0101, 0, 0);
        step(4'b0101, 0, 0);
        chk("t5_pre_early", 32'(arb_if.preempted), 32'd0);
        step(4'b0101, 0, 0);
        chk("t5_pre", 32'(arb_if.preempted), 32'd1);
        chk("t5_grant", 32'(arb_if.grant), 32'b0001);
        step(4'b0101, 0, 0);
        chk("t5_pre_once", 32'(arb_if.preempted), 32'd0);

        // Reset mid-grant
        step(4'b0000, 0, 1);
        step(4'b0100, 0, 0);
        step(4'b0100, 0, 1);
        chk("t6_grant_rst", 32'(arb_if.grant), 32'd0);
        step(4'b1100, 0, 0);
        chk("t6_grant", 32'(arb_if.grant), 32'b0100);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            step(N'($urandom_range(0, 15)), ($urandom_range(0, 9) < 3), ($urandom_range(0, 59) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
